// File: rtl/riscv_lsu_ctrl.sv
// riscv_lsu_ctrl: multi-cycle load/store sequencer for the core's data port.
// Accepts the decoder's memory controls and the ALU address, runs one
// req/ack bus transaction, and stalls the PC until it retires. It also does
// byte-lane steering, byte enables and load sign/zero extension.
// Optional build macro: LSU_TIMEOUT_EN adds an abort after TIMEOUT wait cycles.
module riscv_lsu_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        lsen,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              rdata_valid,
    output logic              misalign,
    output logic              bus_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Unlisted size codes are reported as misaligned so they never reach the bus.
    function automatic logic is_aligned(input logic [2:0] size, input logic [1:0] a);
        case (size)
            3'b000, 3'b100: is_aligned = 1'b1;
            3'b001, 3'b101: is_aligned = ~a[0];
            3'b010:         is_aligned = (a == 2'b00);
            default:        is_aligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] a);
        case (size[1:0])
            2'b00:   byte_en = 4'b0001 << a;
            2'b01:   byte_en = a[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] size, input logic [31:0] w);
        case (size[1:0])
            2'b00:   store_lanes = {4{w[7:0]}};
            2'b01:   store_lanes = {2{w[15:0]}};
            default: store_lanes = w;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] size, input logic [1:0] a,
                                                input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'b00:   b = w[7:0];
            2'b01:   b = w[15:8];
            2'b10:   b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (size)
            3'b000:  load_extend = {{24{b[7]}}, b};
            3'b100:  load_extend = {24'h000000, b};
            3'b001:  load_extend = {{16{h[15]}}, h};
            3'b101:  load_extend = {16'h0000, h};
            default: load_extend = w;
        endcase
    endfunction

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        lsen_q;
    logic [31:0]       wdata_q;
    logic              we_q;
    logic              err_q;
    logic [31:0]       rdata_q;

    logic op_s, aligned_s, accept_s, capture_s, abort_s, stall_s, misalign_s, timeout_s;

    assign op_s      = mem_read | mem_write;
    assign aligned_s = is_aligned(lsen, addr[1:0]);

`ifdef LSU_TIMEOUT_EN
    logic [4:0] cnt_q;

    // Wait counter: zero while outside REQ, counts REQ cycles without ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 5'd0;
        end else if (state_q != S_REQ) begin
            cnt_q <= 5'd0;
        end else if (!bus_ack) begin
            cnt_q <= cnt_q + 5'd1;
        end
    end

    assign timeout_s = (cnt_q == 5'(TIMEOUT - 1));
`else
    // Without the timeout build REQ waits forever; TIMEOUT has no effect.
    assign timeout_s = 1'b0 & (TIMEOUT == 0);
`endif

    // Next-state and per-cycle control decode.
    always_comb begin
        state_d    = state_q;
        accept_s   = 1'b0;
        capture_s  = 1'b0;
        abort_s    = 1'b0;
        stall_s    = 1'b0;
        misalign_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (op_s && aligned_s) begin
                    stall_s  = 1'b1;
                    accept_s = 1'b1;
                    state_d  = S_REQ;
                end else if (op_s) begin
                    misalign_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                stall_s = 1'b1;
                if (bus_ack) begin
                    capture_s = ~we_q;
                    state_d   = S_DONE;
                end else if (timeout_s) begin
                    abort_s = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register and latched access fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            lsen_q  <= 3'b000;
            wdata_q <= 32'h0000_0000;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            if (accept_s) begin
                addr_q  <= addr;
                lsen_q  <= lsen;
                wdata_q <= wdata;
                we_q    <= mem_write & ~mem_read;
                err_q   <= 1'b0;
            end
            if (abort_s) begin
                err_q <= 1'b1;
            end
            if (capture_s) begin
                rdata_q <= load_extend(lsen_q, addr_q[1:0], bus_rdata);
            end
        end
    end

    // Outputs: bus fields come only from latched registers and are zero outside REQ.
    assign stall       = stall_s & ~rst;
    assign misalign    = misalign_s & ~rst;
    assign rdata       = rdata_q;
    assign rdata_valid = (state_q == S_DONE) & ~we_q & ~err_q;
    assign bus_err     = (state_q == S_DONE) & err_q;
    assign bus_req     = (state_q == S_REQ);
    assign bus_we      = bus_req & we_q;
    assign bus_addr    = bus_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign bus_be      = bus_req ? byte_en(lsen_q, addr_q[1:0]) : 4'b0000;
    assign bus_wdata   = bus_req ? store_lanes(lsen_q, wdata_q) : 32'h0000_0000;

endmodule

// File: doc/riscv_lsu_ctrl.md
Name: riscv_lsu_ctrl

Overview:
Multi-cycle load/store sequencer for the single-cycle core's data-memory port.
- Takes the decoder's memory controls (read/write enable, LSen size code) and the ALU-computed address.
- Drives a req/ack data bus and stalls the PC until the access completes.
- Does byte-lane steering, byte enables and load sign/zero extension.
- Sits between the decoder/ALU outputs and the data memory; rdata feeds the MemtoReg writeback mux.

Parameters:
ADDR_W, 32, width of address and bus_addr
TIMEOUT, 16, max cycles waiting for bus_ack before abort (used only with LSU_TIMEOUT_EN)

Ports:
clk  in  1  core clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
mem_read  in  1  decoder: current instruction is a load
mem_write  in  1  decoder: current instruction is a store
lsen  in  3  size code = funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr  in  ADDR_W  effective address from ALU
wdata  in  32  store data (rs2)
stall  out  1  hold PC/regfile write while high
rdata  out  32  extended load result
rdata_valid  out  1  one-cycle pulse; rdata valid for writeback
misalign  out  1  one-cycle pulse; access not performed
bus_err  out  1  one-cycle pulse; access aborted by timeout
bus_req  out  1  bus request, held until bus_ack
bus_we  out  1  1 = write
bus_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
bus_be  out  4  byte enables
bus_wdata  out  32  lane-replicated store data
bus_ack  in  1  access complete this cycle
bus_rdata  in  32  read word, valid when bus_ack

Behaviour:
- Reset (async): state=IDLE, counter=0; all outputs 0 (rdata=0).
- States: IDLE, REQ, DONE.
- op = mem_read|mem_write; mem_read && mem_write both high is treated as a load.
- Alignment rules:
  - H/HU misaligned if addr[0]=1.
  - W misaligned if addr[1:0]!=00.
  - B/BU always aligned.
  - Unlisted lsen codes (011,110,111) are treated as misaligned.
- IDLE:
  - op && aligned: stall=1 (combinational); latch addr, lsen, wdata, direction into registers; -> REQ next edge.
  - op && misaligned: misalign=1 for this cycle, stall=0, no bus activity; stay IDLE.
  - no op: idle, stall=0.
- REQ:
  - bus_req=1, stall=1; bus_* driven from latched registers only and held stable until ack.
  - bus_ack=1: capture extended load data into rdata; -> DONE.
  - Ack in the same cycle req first rises is legal (1-cycle bus): the access takes exactly one REQ cycle.
- DONE:
  - stall=0 so the instruction retires; rdata_valid=1 for loads, 0 for stores; bus_req=0.
  - Always -> IDLE. A following memory op is seen fresh in IDLE; there is no back-to-back issue from DONE.
- Latency: load/store with an immediate ack occupies 3 cycles (IDLE-stall, REQ, DONE); each extra wait cycle adds 1.
- Byte enables:
  - B: 0001<<addr[1:0].
  - H: 0011<<(addr[1]*2).
  - W: 1111.
- Store data lanes:
  - B: wdata[7:0] replicated x4.
  - H: wdata[15:0] replicated x2.
  - W: wdata as-is.
- Load extract:
  - Byte/half selected by addr[1:0]/addr[1].
  - B and H sign-extend from bit 7/15; BU and HU zero-extend.
- rdata holds its last value until the next load completes; only rdata_valid marks a new value.
- Reset mid-operation: bus_req drops immediately (async); no completion pulse; a late bus_ack after reset is ignored in IDLE.
- bus_ack outside REQ: ignored.

Optional Feature:
Macro: LSU_TIMEOUT_EN.
- Defined:
  - 5-bit wait counter clears on entry to REQ and increments each REQ cycle without ack.
  - When counter==TIMEOUT-1 with no ack: -> DONE with bus_err=1, rdata_valid=0, and rdata unchanged.
  - Ack in that same cycle wins: normal completion, no error.
- Not defined:
  - No counter and no abort; REQ waits indefinitely.
  - bus_err is tied to 0.

Test Plan:
- Load word: LW addr=0x100, bus_ack on first REQ cycle with bus_rdata=0xDEADBEEF -> bus_be=1111, bus_addr=0x100, stall high 2 cycles, DONE rdata=0xDEADBEEF with rdata_valid pulse.
- LB vs LBU: addr=0x103, bus_rdata=0x80123456 -> LB rdata=0xFFFFFF80; LBU rdata=0x00000080; bus_be=1000 in both.
- SH addr=0x102, wdata=0x0000ABCD, ack after 3 wait cycles -> bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD held stable 4 REQ cycles, rdata_valid stays 0.
- Misaligned LW addr=0x101 -> misalign pulse 1 cycle, stall=0, bus_req never asserts.
- rst asserted during REQ (wait for ack) -> bus_req=0 and stall=0 in the same cycle; ack pulse 1 cycle later is ignored; next LW completes normally.
- With LSU_TIMEOUT_EN, TIMEOUT=16, bus_ack never asserted -> bus_err pulse after 16 REQ cycles, stall released in DONE, rdata unchanged.
